idct_acc_round: RTL and testbench

//  Downstream neighbour of the shift-add multiplier stage: accumulates its per-coefficient

---
 rtl/idct_pkg.sv | 23 ++
 rtl/idct_round_clip.sv | 38 +++
 rtl/idct_acc_round.sv | 135 +++++++++++++
 tb/tb_idct_acc_round.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/idct_pkg.sv
// Shared constants and types for the IDCT accumulate/round stage.
// Lane codes, pass shifts and default datapath widths.
package idct_pkg;

  localparam logic [1:0] CODE_IDLE = 2'b00;
  localparam logic [1:0] CODE_2L   = 2'b01;
  localparam logic [1:0] CODE_4L   = 2'b10;
  localparam logic [1:0] CODE_BAD  = 2'b11;

  localparam int SHIFT_PASS1 = 7;
  localparam int SHIFT_PASS2 = 12;
  localparam int DEF_WIDTH_Y = 22;
  localparam int DEF_ACC_W   = 24;
  localparam int DEF_OUT_W   = 16;
  localparam int MAX_TERMS   = 4;
  localparam int LANES       = 4;

  typedef enum logic {
    S_IDLE,
    S_ACC
  } state_e;

endpackage

// File: rtl/idct_round_clip.sv
// Combinational round-half-up, arithmetic shift and saturation
// of one accumulated lane sum.
module idct_round_clip
  import idct_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int SHIFT = SHIFT_PASS1,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic signed [ACC_W-1:0] sum,
  output logic signed [OUT_W-1:0] z,
  output logic                    sat
);

  localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [ACC_W:0] RND =
    (SHIFT > 0) ? (ACC_W+1)'(1) << RS : '0;
  localparam logic signed [ACC_W:0] MAXV =
    (ACC_W+1)'((1 << (OUT_W-1)) - 1);
  localparam logic signed [ACC_W:0] MINV = ~MAXV;

  logic signed [ACC_W:0] r;

  // One guard bit so a full-scale sum plus the rounding constant cannot wrap.
  always_comb begin
    r   = ($signed({sum[ACC_W-1], sum}) + RND) >>> SHIFT;
    sat = 1'b0;
    z   = r[OUT_W-1:0];
    if (r > MAXV) begin
      sat = 1'b1;
      z   = MAXV[OUT_W-1:0];
    end else if (r < MINV) begin
      sat = 1'b1;
      z   = MINV[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/idct_acc_round.sv
// Accumulates 1-4 partial-product terms per group, then rounds,
// shifts and saturates the four lane sums into one output vector.
module idct_acc_round
  import idct_pkg::*;
#(
  parameter int WIDTH_Y = DEF_WIDTH_Y,
  parameter int ACC_W   = WIDTH_Y + 2,
  parameter int SHIFT   = SHIFT_PASS1,
  parameter int OUT_W   = DEF_OUT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                code_in,
  input  logic [2:0]                grp_len,
  input  logic signed [WIDTH_Y-1:0] y0,
  input  logic signed [WIDTH_Y-1:0] y1,
  input  logic signed [WIDTH_Y-1:0] y2,
  input  logic signed [WIDTH_Y-1:0] y3,
  output logic                      out_valid,
  output logic [1:0]                out_code,
  output logic signed [OUT_W-1:0]   z0,
  output logic signed [OUT_W-1:0]   z1,
  output logic signed [OUT_W-1:0]   z2,
  output logic signed [OUT_W-1:0]   z3,
  output logic [3:0]                sat,
  output logic                      err
);

  state_e state_q, state_d;

  logic [1:0]               code_q;
  logic [2:0]               len_q;
  logic [2:0]               cnt_q;
  logic signed [ACC_W-1:0]  acc_q [LANES];
  logic signed [OUT_W-1:0]  z_q   [LANES];

  logic signed [WIDTH_Y-1:0] y   [LANES];
  logic signed [ACC_W-1:0]   ext [LANES];
  logic signed [ACC_W-1:0]   sum [LANES];
  logic signed [OUT_W-1:0]   zc  [LANES];
  logic [3:0]                satc;

  logic       term, busy, done, mask_hi;
  logic [1:0] eff_code;
  logic [2:0] eff_len, len_in, cnt_nx;

  assign y[0] = y0;
  assign y[1] = y1;
  assign y[2] = y2;
  assign y[3] = y3;

  assign z0 = z_q[0];
  assign z1 = z_q[1];
  assign z2 = z_q[2];
  assign z3 = z_q[3];

  // The first term of a group loads, so its code and length come from the inputs.
  always_comb begin
    term     = (code_in == CODE_2L) || (code_in == CODE_4L);
    busy     = (state_q == S_ACC);
    len_in   = (grp_len == '0) ? 3'(MAX_TERMS) : grp_len;
    eff_code = busy ? code_q : code_in;
    eff_len  = busy ? len_q : len_in;
    cnt_nx   = busy ? cnt_q + 3'd1 : 3'd1;
    done     = term && (cnt_nx == eff_len);
    mask_hi  = (eff_code == CODE_2L);
    state_d  = state_q;
    if (term)
      state_d = done ? S_IDLE : S_ACC;
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      ext[i] = {{(ACC_W-WIDTH_Y){y[i][WIDTH_Y-1]}}, y[i]};
      if (i >= 2 && mask_hi)
        ext[i] = '0;
      sum[i] = (busy ? acc_q[i] : '0) + ext[i];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    idct_round_clip #(
      .ACC_W (ACC_W),
      .SHIFT (SHIFT),
      .OUT_W (OUT_W)
    ) u_rc (
      .sum (sum[g]),
      .z   (zc[g]),
      .sat (satc[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      code_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      out_code  <= '0;
      sat       <= '0;
      err       <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        acc_q[i] <= '0;
        z_q[i]   <= '0;
      end
    end else begin
      out_valid <= done;
      if (term) begin
        code_q <= eff_code;
        len_q  <= eff_len;
        cnt_q  <= done ? '0 : cnt_nx;
        for (int i = 0; i < LANES; i++)
          acc_q[i] <= sum[i];
      end
      if (done) begin
        out_code <= eff_code;
        sat      <= satc;
        for (int i = 0; i < LANES; i++)
          z_q[i] <= zc[i];
      end
      if ((code_in == CODE_BAD) ||
          (busy && term && code_in != code_q) ||
          (!busy && term && grp_len == '0))
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_idct_acc_round.sv
// Table-driven bench with an output scoreboard for idct_acc_round
// (default parameters: SHIFT 7, 16-bit signed outputs).
module tb_idct_acc_round;
  import idct_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        code_in;
  logic [2:0]        grp_len;
  logic signed [21:0] y0, y1, y2, y3;
  logic              out_valid;
  logic [1:0]        out_code;
  logic signed [15:0] z0, z1, z2, z3;
  logic [3:0]        sat;
  logic              err;

  idct_acc_round dut (
    .clk       (clk),
    .rst       (rst),
    .code_in   (code_in),
    .grp_len   (grp_len),
    .y0        (y0),
    .y1        (y1),
    .y2        (y2),
    .y3        (y3),
    .out_valid (out_valid),
    .out_code  (out_code),
    .z0        (z0),
    .z1        (z1),
    .z2        (z2),
    .z3        (z3),
    .sat       (sat),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] len;
    logic [1:0] code;
    int y0, y1, y2, y3;
    int z0, z1, z2, z3;
    logic [3:0] sat;
  } vec_t;

  typedef struct {
    logic [1:0] code;
    int z0, z1, z2, z3;
    logic [3:0] sat;
    int due;
  } exp_t;

  exp_t sb[$];
  int   cyc  = 0;
  int   nvec = 0;
  int   nerr = 0;
  int   ngrp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    nvec++;
    if (act != req) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", nm, act, req);
    end
  endtask

  // Golden model of round-half-up >>> 7 then clip to int16.
  function automatic void model(input longint s, output int z, output bit st);
    longint r;
    r  = (s + 64) >>> 7;
    st = 1'b0;
    z  = int'(r);
    if (r > 32767) begin
      z = 32767; st = 1'b1;
    end else if (r < -32768) begin
      z = -32768; st = 1'b1;
    end
  endfunction

  task automatic push(input logic [1:0] c, input int a, input int b,
                      input int d, input int e, input logic [3:0] s);
    exp_t x;
    x.code = c; x.z0 = a; x.z1 = b; x.z2 = d; x.z3 = e;
    x.sat = s; x.due = cyc + 1;
    sb.push_back(x);
  endtask

  task automatic push_model(input logic [1:0] c, input longint s0,
                            input longint s1, input longint s2, input longint s3);
    int a, b, d, e;
    bit t0, t1, t2, t3;
    model(s0, a, t0);
    model(s1, b, t1);
    model(s2, d, t2);
    model(s3, e, t3);
    push(c, a, b, d, e, {t3, t2, t1, t0});
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (out_valid) begin
      nvec++;
      if (sb.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_out: cyc=%0d z0=%0d", cyc, z0);
      end else begin
        x = sb.pop_front();
        ngrp++;
        if (out_code !== x.code || int'(z0) != x.z0 || int'(z1) != x.z1 ||
            int'(z2) != x.z2 || int'(z3) != x.z3 || sat !== x.sat || cyc != x.due) begin
          nerr++;
          $display("FAIL grp%0d: got code=%b z=%0d,%0d,%0d,%0d sat=%b cyc=%0d; want code=%b z=%0d,%0d,%0d,%0d sat=%b cyc=%0d",
                   ngrp, out_code, z0, z1, z2, z3, sat, cyc,
                   x.code, x.z0, x.z1, x.z2, x.z3, x.sat, x.due);
        end
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      x = sb.pop_front();
      nvec++;
      nerr++;
      $display("FAIL missing_out: no out_valid at cyc=%0d, want z0=%0d", x.due, x.z0);
    end
  end

  task automatic drive(input logic [1:0] c, input logic [2:0] l,
                       input int a, input int b, input int d, input int e);
    @(posedge clk);
    #1;
    code_in = c; grp_len = l;
    y0 = 22'(a); y1 = 22'(b); y2 = 22'(d); y3 = 22'(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(CODE_IDLE, 3'd0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; code_in = CODE_IDLE;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, int'(out_valid), 0);
    chk({tag, "_z"}, int'(z0) | int'(z1) | int'(z2) | int'(z3), 0);
    chk({tag, "_code_sat_err"}, int'({out_code, sat, err}), 0);
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{3'd4, CODE_4L, 6400, 0, 0, 0, 200, 0, 0, 0, 4'b0000};
    tbl[1] = '{3'd4, CODE_4L, -6400, 0, 0, 0, -200, 0, 0, 0, 4'b0000};
    tbl[2] = '{3'd4, CODE_4L, 2097151, -2097152, 0, 0, 32767, -32768, 0, 0, 4'b0011};
    tbl[3] = '{3'd2, CODE_2L, 1000, -1000, 123, 123, 16, -16, 0, 0, 4'b0000};
    tbl[4] = '{3'd1, CODE_4L, 64, -64, 63, -65, 1, 0, 0, -1, 4'b0000};
    tbl[5] = '{3'd3, CODE_4L, 100, 200, 300, -300, 2, 5, 7, -7, 4'b0000};
    tbl[6] = '{3'd4, CODE_4L, 1048576, 1048544, -1048576, -1048608,
               32767, 32767, -32768, -32768, 4'b1001};

    rst = 1'b1; code_in = CODE_IDLE; grp_len = 3'd0;
    y0 = '0; y1 = '0; y2 = '0; y3 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_zero("reset");

    // Table groups issued back to back.
    for (int v = 0; v < 7; v++) begin
      for (int t = 0; t < int'(tbl[v].len); t++)
        drive(tbl[v].code, tbl[v].len, tbl[v].y0, tbl[v].y1, tbl[v].y2, tbl[v].y3);
      push(tbl[v].code, tbl[v].z0, tbl[v].z1, tbl[v].z2, tbl[v].z3, tbl[v].sat);
    end
    idle(3);
    chk("err_clean_tbl", int'(err), 0);

    // Bubble inside group 1, group 2 follows with no gap.
    drive(CODE_4L, 3'd2, 500, -300, 7, 0);
    idle(1);
    drive(CODE_4L, 3'd2, 300, -300, 7, 900);
    push_model(CODE_4L, 800, -600, 14, 900);
    drive(CODE_4L, 3'd2, -1000, 10, 0, 0);
    drive(CODE_4L, 3'd0, -1000, 10, 0, 5);
    push_model(CODE_4L, -2000, 20, 0, 5);
    idle(3);
    chk("err_clean_seq", int'(err), 0);

    // Code switch mid-group keeps the latched four-lane mask.
    drive(CODE_4L, 3'd2, 256, 128, 640, 0);
    drive(CODE_2L, 3'd2, 256, 128, 640, 1280);
    push_model(CODE_4L, 512, 256, 1280, 1280);
    idle(2);
    chk("err_switch", int'(err), 1);
    drive(CODE_2L, 3'd1, 200, 0, 5000, 5000);
    push_model(CODE_2L, 200, 0, 0, 0);
    idle(3);
    chk("err_sticky", int'(err), 1);

    // Reset in the middle of a group.
    drive(CODE_4L, 3'd4, 9999, 9999, 9999, 9999);
    drive(CODE_4L, 3'd4, 9999, 9999, 9999, 9999);
    do_reset();
    chk_zero("rst_mid");
    drive(CODE_4L, 3'd2, 640, -640, 1, 0);
    drive(CODE_4L, 3'd2, 640, -640, 1, 0);
    push_model(CODE_4L, 1280, -1280, 2, 0);
    idle(3);
    chk("err_after_rst", int'(err), 0);

    // Illegal code acts as a bubble but flags err.
    drive(CODE_BAD, 3'd1, 5000, 5000, 5000, 5000);
    idle(2);
    chk("err_bad_code", int'(err), 1);
    drive(CODE_4L, 3'd1, 128, 0, 0, 0);
    push_model(CODE_4L, 128, 0, 0, 0);
    idle(3);

    // grp_len 0 means four terms and flags err.
    do_reset();
    chk("err_rst2", int'(err), 0);
    for (int t = 0; t < 4; t++)
      drive(CODE_4L, 3'd0, 128, -128, 0, 3);
    push_model(CODE_4L, 512, -512, 0, 12);
    idle(3);
    chk("err_len0", int'(err), 1);

    idle(4);
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
